mem_wb_skid_reg: RTL and testbench
==================================

Name: mem_wb_skid_reg

Overview:
- Parametrised successor to the single-entry MEM/WB pipeline register.
- Sits between the MEM stage and the register-file write-back port.
- Adds a ready/valid handshake, a 2-entry skid buffer, flush, and a register-write qualifier.
- The forwarding output is qualified (valid, write-enable, Rd≠0), so EX forwarding logic never sees stale or bubble entries.

Parameters:
- OPC_W, 11, opcode field width (bits).
- DATA_W, 32, write-back data width.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- busy_line  in  1  global stall; freezes all state, blocks enqueue and dequeue.
- flush  in  1  discard all held entries.
- in_valid  in  1  MEM stage presents an entry.
- in_ready  out  1  stage can accept (not full, not busy_line).
- in_opcode  in  OPC_W  opcode of the incoming entry.
- in_data  in  DATA_W  write-back data.
- in_rd  in  RD_W  destination register.
- in_we  in  1  entry writes the register file.
- out_valid  out  1  head entry valid.
- out_ready  in  1  write-back consumes the head.
- out_opcode  out  OPC_W  head opcode.
- out_data  out  DATA_W  head data.
- out_rd  out  RD_W  head Rd.
- out_we  out  1  head write-enable, gated by out_valid.
- fwd_valid  out  1  out_valid & out_we & (out_rd≠0).
- fwd_data  out  DATA_W  head data.
- fwd_rd  out  RD_W  head Rd when fwd_valid, else 0.

Behaviour:
- Reset (rst=1 at posedge), clearing all state:
  - count=0.
  - head and skid opcode/data/rd/we all zero.
  - out_valid=0, fwd_valid=0, fwd_rd=0.
  - Reset overrides flush, busy_line and the handshakes.
- Storage: head register drives out_*; skid register holds the second entry. count ∈ {0,1,2}; states EMPTY, ONE, FULL.
- in_ready = (count≠2) & ~busy_line. Combinational; must not depend on in_valid or out_ready.
- enq = in_valid & in_ready. deq = out_valid & out_ready & ~busy_line.
- Transitions, evaluated only when flush=0:
  - EMPTY: enq → ONE, head←in.
  - ONE: enq&deq → ONE, head←in. enq&~deq → FULL, skid←in. deq&~enq → EMPTY. Neither → hold.
  - FULL: deq → ONE, head←skid (no enq possible). No deq → hold.
- Ordering: strictly FIFO; the entry in skid is always younger than head.
- Latency: an entry enqueued into EMPTY appears on out_* the cycle after acceptance (1-cycle latency, matching the old register).
- Throughput: 1 entry/cycle when out_ready is held high.
- busy_line=1: no register changes; out_* hold their values; in_ready=0.
- flush=1 at posedge:
  - count←0 and out_valid←0 next cycle.
  - An enq in the same cycle is dropped; a deq in the same cycle still counts as consumed by the sink.
  - flush wins over busy_line.
  - Data fields need not clear on flush; out_valid gates them.
- Entries with in_we=0 are carried and delivered normally, with out_we=0.
- Holding rules:
  - out_valid=1 with out_ready=0: out_* stable until accepted.
  - Bench checks that in_* are not sampled unless enq.
- No arithmetic; all widths pass through unchanged.

Optional Feature:
- Macro WB_FWD_LOOKUP_EN.
- When defined, adds these ports:
  - lk_rs1, lk_rs2 (in, RD_W).
  - lk_hit1, lk_hit2 (out, 1).
  - lk_data1, lk_data2 (out, DATA_W).
- Lookup is combinational over valid entries with we=1 and rd==rs.
  - Priority: skid (younger) first, then head.
  - rs=0 never hits.
  - On a miss, data is 0.
- When undefined: those ports do not exist; only fwd_* forwarding of the head is provided.

Test Plan:
- Reset then idle: rst=1 two cycles → out_valid=0, fwd_valid=0, fwd_rd=0, in_ready=1 after reset drops.
- Streaming: out_ready=1; enqueue data 0x11,0x22,0x33 on rd 1,2,3 back-to-back → out_data 0x11,0x22,0x33 on consecutive cycles starting one cycle after the first enq; in_ready stays 1.
- Back-pressure fill:
  - Stimulus: out_ready=0; enqueue 0xA0 (rd 4), then 0xB0 (rd 5).
  - Response: in_ready=0 after the second; out_data=0xA0 held.
  - Then out_ready=1 → 0xA0, then 0xB0; in_ready returns to 1.
- busy_line: FULL state, busy_line=1 for 3 cycles with out_ready=1 and in_valid=1 → no state change, in_ready=0; on release, drains in order.
- Flush: FULL state, flush=1 with in_valid=1 (data 0xCC) → next cycle out_valid=0, count=0; 0xCC never appears at out.
- Forwarding qualification:
  - Entry rd=0, we=1 → fwd_valid=0.
  - Entry rd=7, we=0 → fwd_valid=0.
  - Entry rd=7, we=1, data 0xDEADBEEF → fwd_valid=1, fwd_rd=7.
  - With WB_FWD_LOOKUP_EN, head rd=7=0x1 and skid rd=7=0x2: lk_rs1=7 → hit, data 0x2.

Source files
------------

// File: rtl/mem_wb_skid_reg_if.sv
// MEM/WB skid-register bus: MEM-stage enqueue side, write-back dequeue side,
// head forwarding outputs. The lookup ports exist only when WB_FWD_LOOKUP_EN
// is defined.
interface mem_wb_skid_reg_if #(
  parameter int unsigned OPC_W  = 11,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
);
  logic              busy_line;
  logic              flush;

  logic              in_valid;
  logic              in_ready;
  logic [OPC_W-1:0]  in_opcode;
  logic [DATA_W-1:0] in_data;
  logic [RD_W-1:0]   in_rd;
  logic              in_we;

  logic              out_valid;
  logic              out_ready;
  logic [OPC_W-1:0]  out_opcode;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
  logic              out_we;

  logic              fwd_valid;
  logic [DATA_W-1:0] fwd_data;
  logic [RD_W-1:0]   fwd_rd;

`ifdef WB_FWD_LOOKUP_EN
  logic [RD_W-1:0]   lk_rs1;
  logic [RD_W-1:0]   lk_rs2;
  logic              lk_hit1;
  logic              lk_hit2;
  logic [DATA_W-1:0] lk_data1;
  logic [DATA_W-1:0] lk_data2;
`endif

  // Environment side: MEM stage producer, write-back consumer, EX lookups.
  modport master (
`ifdef WB_FWD_LOOKUP_EN
    output lk_rs1, lk_rs2,
    input  lk_hit1, lk_hit2, lk_data1, lk_data2,
`endif
    output busy_line, flush,
    output in_valid, in_opcode, in_data, in_rd, in_we,
    input  in_ready,
    input  out_valid, out_opcode, out_data, out_rd, out_we,
    output out_ready,
    input  fwd_valid, fwd_data, fwd_rd
  );

  // Pipeline-register side.
  modport slave (
`ifdef WB_FWD_LOOKUP_EN
    input  lk_rs1, lk_rs2,
    output lk_hit1, lk_hit2, lk_data1, lk_data2,
`endif
    input  busy_line, flush,
    input  in_valid, in_opcode, in_data, in_rd, in_we,
    output in_ready,
    output out_valid, out_opcode, out_data, out_rd, out_we,
    input  out_ready,
    output fwd_valid, fwd_data, fwd_rd
  );
endinterface

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with ready/valid handshake and a 2-entry skid
// buffer. The head entry drives out_*; the skid entry holds a younger one.
// Optional feature macro: WB_FWD_LOOKUP_EN adds a combinational two-port
// Rd lookup across both held entries (younger entry has priority).
module mem_wb_skid_reg #(
  parameter int unsigned OPC_W  = 11,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input logic              clk,
  input logic              rst,
  mem_wb_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q, state_d;

  logic [OPC_W-1:0]  head_opc_q, head_opc_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [RD_W-1:0]   head_rd_q, head_rd_d;
  logic              head_we_q, head_we_d;

  logic [OPC_W-1:0]  skid_opc_q, skid_opc_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
  logic              skid_we_q, skid_we_d;

  logic in_ready;
  logic out_valid;
  logic enq;
  logic deq;

  // Handshake qualifiers; busy_line blocks both sides.
  always_comb begin
    in_ready  = (state_q != StFull) && !bus.busy_line;
    out_valid = (state_q != StEmpty);
    enq       = bus.in_valid && in_ready;
    deq       = out_valid && bus.out_ready && !bus.busy_line;
  end

  // Next-state: FIFO occupancy and entry movement. Flush drops any enq.
  always_comb begin
    state_d     = state_q;
    head_opc_d  = head_opc_q;
    head_data_d = head_data_q;
    head_rd_d   = head_rd_q;
    head_we_d   = head_we_q;
    skid_opc_d  = skid_opc_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    skid_we_d   = skid_we_q;
    if (bus.flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (enq) begin
            state_d     = StOne;
            head_opc_d  = bus.in_opcode;
            head_data_d = bus.in_data;
            head_rd_d   = bus.in_rd;
            head_we_d   = bus.in_we;
          end
        end
        StOne: begin
          if (enq && deq) begin
            head_opc_d  = bus.in_opcode;
            head_data_d = bus.in_data;
            head_rd_d   = bus.in_rd;
            head_we_d   = bus.in_we;
          end else if (enq) begin
            state_d     = StFull;
            skid_opc_d  = bus.in_opcode;
            skid_data_d = bus.in_data;
            skid_rd_d   = bus.in_rd;
            skid_we_d   = bus.in_we;
          end else if (deq) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (deq) begin
            state_d     = StOne;
            head_opc_d  = skid_opc_q;
            head_data_d = skid_data_q;
            head_rd_d   = skid_rd_q;
            head_we_d   = skid_we_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State registers; synchronous reset overrides flush, busy and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      head_opc_q  <= '0;
      head_data_q <= '0;
      head_rd_q   <= '0;
      head_we_q   <= 1'b0;
      skid_opc_q  <= '0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
      skid_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_opc_q  <= head_opc_d;
      head_data_q <= head_data_d;
      head_rd_q   <= head_rd_d;
      head_we_q   <= head_we_d;
      skid_opc_q  <= skid_opc_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
      skid_we_q   <= skid_we_d;
    end
  end

  // Head outputs; forwarding never exposes bubbles, non-writes or x0.
  always_comb begin
    bus.in_ready   = in_ready;
    bus.out_valid  = out_valid;
    bus.out_opcode = head_opc_q;
    bus.out_data   = head_data_q;
    bus.out_rd     = head_rd_q;
    bus.out_we     = head_we_q && out_valid;
    bus.fwd_valid  = out_valid && head_we_q && (head_rd_q != '0);
    bus.fwd_data   = head_data_q;
    bus.fwd_rd     = bus.fwd_valid ? head_rd_q : '0;
  end

`ifdef WB_FWD_LOOKUP_EN
  logic skid_live;
  logic head_live;

  // Lookup across live writing entries; skid is younger so it wins.
  always_comb begin
    skid_live    = (state_q == StFull) && skid_we_q;
    head_live    = (state_q != StEmpty) && head_we_q;
    bus.lk_hit1  = 1'b0;
    bus.lk_data1 = '0;
    bus.lk_hit2  = 1'b0;
    bus.lk_data2 = '0;
    if (bus.lk_rs1 != '0) begin
      if (skid_live && (skid_rd_q == bus.lk_rs1)) begin
        bus.lk_hit1  = 1'b1;
        bus.lk_data1 = skid_data_q;
      end else if (head_live && (head_rd_q == bus.lk_rs1)) begin
        bus.lk_hit1  = 1'b1;
        bus.lk_data1 = head_data_q;
      end
    end
    if (bus.lk_rs2 != '0) begin
      if (skid_live && (skid_rd_q == bus.lk_rs2)) begin
        bus.lk_hit2  = 1'b1;
        bus.lk_data2 = skid_data_q;
      end else if (head_live && (head_rd_q == bus.lk_rs2)) begin
        bus.lk_hit2  = 1'b1;
        bus.lk_data2 = head_data_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Self-checking bench for mem_wb_skid_reg: directed scenarios followed by
// random traffic, all checked against a queue-based model of a 2-deep FIFO.
module tb_mem_wb_skid_reg;
  localparam int unsigned OPC_W  = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              we;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_wb_skid_reg_if #(.OPC_W(OPC_W), .DATA_W(DATA_W), .RD_W(RD_W)) bus ();

  mem_wb_skid_reg #(.OPC_W(OPC_W), .DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  ent_t q[$];
  bit   zero_head = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

`ifdef WB_FWD_LOOKUP_EN
  // Youngest matching writer wins; x0 never matches.
  task automatic lk_check(input string nm, input logic [RD_W-1:0] rs,
                          input logic hit, input logic [DATA_W-1:0] data);
    logic             e_hit;
    logic [DATA_W-1:0] e_data;
    e_hit  = 1'b0;
    e_data = '0;
    if (rs != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!e_hit && q[i].we && q[i].rd == rs) begin
          e_hit  = 1'b1;
          e_data = q[i].data;
        end
      end
    end
    chk({nm, "_hit"}, 64'(hit), 64'(e_hit));
    chk({nm, "_data"}, 64'(data), 64'(e_data));
  endtask
`endif

  // Monitor: outputs are stable at negedge; compare, then advance the model
  // by what the upcoming posedge will do with the currently driven inputs.
  always @(negedge clk) begin
    bit   e_valid;
    bit   e_fwd;
    bit   m_rdy;
    bit   m_enq;
    bit   m_deq;
    ent_t h;
    ent_t n;
    e_valid = (q.size() != 0);
    h = e_valid ? q[0] : '0;
    e_fwd = e_valid && h.we && (h.rd != 0);
    chk("out_valid", 64'(bus.out_valid), 64'(e_valid));
    chk("in_ready", 64'(bus.in_ready), 64'((q.size() < 2) && !bus.busy_line));
    chk("fwd_valid", 64'(bus.fwd_valid), 64'(e_fwd));
    chk("fwd_rd", 64'(bus.fwd_rd), e_fwd ? 64'(h.rd) : 64'd0);
    if (e_valid) begin
      chk("out_data", 64'(bus.out_data), 64'(h.data));
      chk("out_rd", 64'(bus.out_rd), 64'(h.rd));
      chk("out_opcode", 64'(bus.out_opcode), 64'(h.opc));
      chk("out_we", 64'(bus.out_we), 64'(h.we));
      chk("fwd_data", 64'(bus.fwd_data), 64'(h.data));
    end else begin
      chk("out_we_idle", 64'(bus.out_we), 64'd0);
      if (zero_head) begin
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_rd", 64'(bus.out_rd), 64'd0);
        chk("rst_opcode", 64'(bus.out_opcode), 64'd0);
      end
    end
`ifdef WB_FWD_LOOKUP_EN
    lk_check("lk1", bus.lk_rs1, bus.lk_hit1, bus.lk_data1);
    lk_check("lk2", bus.lk_rs2, bus.lk_hit2, bus.lk_data2);
`endif
    if (rst) begin
      q.delete();
      zero_head = 1'b1;
    end else begin
      m_rdy = (q.size() < 2) && !bus.busy_line;
      m_enq = bus.in_valid && m_rdy;
      m_deq = (q.size() != 0) && bus.out_ready && !bus.busy_line;
      if (m_deq) void'(q.pop_front());
      if (bus.flush) begin
        q.delete();
      end else if (m_enq) begin
        n.opc  = bus.in_opcode;
        n.data = bus.in_data;
        n.rd   = bus.in_rd;
        n.we   = bus.in_we;
        q.push_back(n);
        zero_head = 1'b0;
      end
    end
  end

  task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd,
                     input logic we, input logic ordy, input logic busy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_rd     = rd;
    bus.in_we     = we;
    bus.in_opcode = OPC_W'($urandom);
    bus.out_ready = ordy;
    bus.busy_line = busy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_rd     = '0;
    bus.in_we     = 1'b0;
    bus.in_opcode = '0;
    bus.out_ready = 1'b0;
    bus.busy_line = 1'b0;
    bus.flush     = 1'b0;
`ifdef WB_FWD_LOOKUP_EN
    bus.lk_rs1 = 5'd7;
    bus.lk_rs2 = 5'd5;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 32'h0, 0, 0, 1, 0, 0);

    // Streaming at one entry per cycle.
    cyc(1, 32'h11, 1, 1, 1, 0, 0);
    cyc(1, 32'h22, 2, 1, 1, 0, 0);
    cyc(1, 32'h33, 3, 1, 1, 0, 0);
    repeat (2) cyc(0, 32'h99, 9, 1, 1, 0, 0);

    // Back-pressure fill, hold, drain.
    cyc(1, 32'hA0, 4, 1, 0, 0, 0);
    cyc(1, 32'hB0, 5, 1, 0, 0, 0);
    repeat (2) cyc(1, 32'hF0, 6, 1, 0, 0, 0);
    repeat (3) cyc(0, 32'h0, 0, 0, 1, 0, 0);

    // Stall while full with both sides requesting.
    cyc(1, 32'hA1, 4, 1, 0, 0, 0);
    cyc(1, 32'hB1, 5, 1, 0, 0, 0);
    repeat (3) cyc(1, 32'hEE, 6, 1, 1, 1, 0);
    repeat (3) cyc(0, 32'h0, 0, 0, 1, 0, 0);

    // Flush while full; 0xCC must never surface.
    cyc(1, 32'hA2, 4, 1, 0, 0, 0);
    cyc(1, 32'hB2, 5, 1, 0, 0, 0);
    cyc(1, 32'hCC, 8, 1, 0, 0, 1);
    repeat (2) cyc(0, 32'h0, 0, 0, 1, 0, 0);

    // Flush together with busy_line.
    cyc(1, 32'hA3, 4, 1, 0, 0, 0);
    cyc(1, 32'hCD, 8, 1, 1, 1, 1);
    repeat (2) cyc(0, 32'h0, 0, 0, 1, 0, 0);

    // Forwarding qualification.
    cyc(1, 32'h1234, 0, 1, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 1, 0, 0);
    cyc(1, 32'h5678, 7, 0, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 1, 0, 0);
    cyc(1, 32'hDEADBEEF, 7, 1, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 1, 0, 0);

    // Two writers of x7 held; younger one must win the lookup.
    cyc(1, 32'h1, 7, 1, 0, 0, 0);
    cyc(1, 32'h2, 7, 1, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 32'h0, 0, 0, 1, 0, 0);

    // Random traffic including occasional reset.
    for (int i = 0; i < 3000; i++) begin
`ifdef WB_FWD_LOOKUP_EN
      bus.lk_rs1 = RD_W'($urandom_range(0, 7));
      bus.lk_rs2 = RD_W'($urandom_range(0, 7));
`endif
      rst = ($urandom_range(0, 199) == 0);
      cyc(($urandom_range(0, 9) < 7), $urandom, RD_W'($urandom_range(0, 7)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
    end
    rst = 1'b0;
    repeat (4) cyc(0, 32'h0, 0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
